// File: rtl/counter_8b_rtl_pkg.sv
// Shared constants for the 8-bit delay/timeout counter.
//   CNT_W : counter width in bits (fixed at 8)
package counter_8b_rtl_pkg;

  localparam int CNT_W = 8;

endpackage

// File: rtl/counter_8b_rtl_reg_rst_8b.sv
// 8-bit register with asynchronous active-low reset to zero and a
// synchronous load enable.
//   clk   : clock, rising edge
//   rst_n : asynchronous reset, active low, clears q to 0
//   en    : when 1, q takes d on the rising edge; otherwise q holds
//   d     : next value
//   q     : registered value
module reg_rst_8b
  import counter_8b_rtl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] d,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/counter_8b_rtl.sv
// Loadable 8-bit down-counter with a completion flag, used as a generic
// delay/timeout timer. A load takes priority and replaces any count in
// progress; otherwise the count decrements once per cycle and holds at 0.
//   clk   : clock, rising edge
//   rst   : asynchronous reset, active low, forces count to 0
//   in    : value to load, only looked at when load=1
//   load  : load request
//   count : current counter value (register output)
//   done  : 1 whenever count == 0 (combinational)
module counter_8b_rtl
  import counter_8b_rtl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] in,
  input  logic             load,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  logic [CNT_W-1:0] w_count;
  logic [CNT_W-1:0] w_next;
  logic             w_zero;
  logic             w_en;

  assign w_zero = (w_count == '0);

  // Register is only enabled for a load or a non-zero count, so the
  // count - 1 path can never be captured at zero and wrap to 255.
  assign w_en   = load | ~w_zero;
  assign w_next = load ? in : (w_count - CNT_W'(1));

  reg_rst_8b u_cnt_reg (
    .clk   (clk),
    .rst_n (rst),
    .en    (w_en),
    .d     (w_next),
    .q     (w_count)
  );

  assign count = w_count;
  assign done  = w_zero;

endmodule

// File: tb/tb_counter_8b_rtl.sv
module tb_counter_8b_rtl;
  import counter_8b_rtl_pkg::*;

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic             dn;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             load;
  logic [CNT_W-1:0] in_v;
  logic [CNT_W-1:0] count;
  logic             done;

  exp_t             sb_q[$];
  logic [CNT_W-1:0] m_count;
  int               n_checks = 0;
  int               n_pass   = 0;

  always #5 clk = ~clk;

  counter_8b_rtl dut (
    .clk   (clk),
    .rst   (rst),
    .in    (in_v),
    .load  (load),
    .count (count),
    .done  (done)
  );

  task automatic check(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
  endtask

  // Drive one cycle of stimulus, push the reference result at the edge,
  // then pop and compare 1 time unit after the edge.
  task automatic step(input logic ld, input logic [CNT_W-1:0] v, input string tag);
    exp_t e;
    load = ld;
    in_v = v;
    @(posedge clk);
    if (!rst)                m_count = '0;
    else if (ld)             m_count = v;
    else if (m_count != '0)  m_count = m_count - 8'd1;
    sb_q.push_back('{cnt: m_count, dn: (m_count == '0)});
    #1;
    e = sb_q.pop_front();
    check({tag, "_count"}, int'(count), int'(e.cnt));
    check({tag, "_done"},  int'(done),  int'(e.dn));
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom_range(0, 255)), tag);
  endtask

  initial begin
    int seq3[4];
    seq3 = '{3, 2, 1, 0};
    rst = 1'b0; load = 1'b0; in_v = '0; m_count = '0;
    #1;
    check("reset_count", int'(count), 0);
    check("reset_done",  int'(done),  1);
    #6 rst = 1'b1;

    // Basic: load 3 -> 3,2,1,0 then idle at 0
    step(1'b1, 8'd3, "basic_load");
    check("basic_seq", int'(count), seq3[0]);
    for (int i = 1; i < 4; i++) begin
      step(1'b0, 8'd0, "basic_dec");
      check("basic_seq", int'(count), seq3[i]);
    end
    idle(3, "basic_idle");
    check("basic_idle_done", int'(done), 1);

    // Small values
    step(1'b1, 8'd1, "load1");
    check("load1_done", int'(done), 0);
    step(1'b0, 8'd0, "load1_dec");
    check("load1_zero", int'(count), 0);
    step(1'b1, 8'd9, "load9");
    step(1'b1, 8'd0, "load0");
    check("load0_done", int'(done), 1);

    // Max: 255 down to 0, then hold (no wrap)
    step(1'b1, 8'd255, "max_load");
    check("max_first", int'(count), 255);
    idle(255, "max_dec");
    check("max_end", int'(count), 0);
    idle(4, "max_hold");
    check("max_nowrap", int'(count), 0);

    // Consecutive loads and reload mid-count
    step(1'b1, 8'd5, "b2b_5");
    step(1'b1, 8'd7, "b2b_7");
    check("b2b_seq", int'(count), 7);
    idle(3, "b2b_dec");
    check("b2b_at4", int'(count), 4);
    step(1'b1, 8'd2, "reload2");
    idle(2, "reload_dec");
    check("reload_end", int'(count), 0);

    // Reset mid-operation
    step(1'b1, 8'd10, "mid_load");
    idle(3, "mid_dec");
    check("mid_before", int'(count), 7);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_count", int'(count), 0);
    check("mid_rst_done",  int'(done),  1);
    step(1'b1, 8'd200, "rst_hold_load");
    rst = 1'b1;
    step(1'b0, 8'd77, "post_rst_idle");
    step(1'b1, 8'd4, "post_rst_load");
    idle(5, "post_rst_dec");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
